// File: rtl/conv_pkg.sv
// Shared constants and types for the conv core output path.
// Geometry, bias and FSM state encoding used by the serializer.
package conv_pkg;

  localparam int WORD_LENGTH        = 8;
  localparam int DOUBLE_WORD_LENGTH = 2 * WORD_LENGTH;
  localparam int IMAGE_SIZE         = 28;
  localparam int KERNEL_SIZE        = 5;
  localparam int OUTPUT_SIZE        = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int OUT_WORDS          = OUTPUT_SIZE * OUTPUT_SIZE;
  localparam int OUT_IDX_W          = $clog2(OUT_WORDS);

  localparam logic [DOUBLE_WORD_LENGTH-1:0] BIAS = 16'd14;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

endpackage

// File: rtl/conv_out_serializer_bias_add_sat.sv
// Signed word plus constant bias, formed at one extra bit.
// Either wraps to the word width or clamps to the signed range.
module bias_add_sat #(
  parameter int                 width    = 16,
  parameter logic [width-1:0]   bias     = 16'd14,
  parameter bit                 saturate = 1'b0
) (
  input  logic [width-1:0] a,
  output logic [width-1:0] y
);

  logic [width:0] sum;
  logic           ovf;

  localparam logic [width-1:0] MAX_POS = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0] MAX_NEG = {1'b1, {(width-1){1'b0}}};

  // Sign-extended add; overflow when the two top bits disagree
  always_comb begin
    sum = {a[width-1], a} + {bias[width-1], bias};
    ovf = sum[width] ^ sum[width-1];
    y   = sum[width-1:0];
    if (saturate && ovf) begin
      y = sum[width] ? MAX_NEG : MAX_POS;
    end
  end

endmodule

// File: rtl/conv_out_serializer.sv
// Captures the conv core result map in one cycle and streams it,
// biased, one word per valid/ready handshake in row-major order.
module conv_out_serializer
  import conv_pkg::*;
#(
  parameter int double_word_length = DOUBLE_WORD_LENGTH,
  parameter int image_size         = IMAGE_SIZE,
  parameter int kernel_size        = KERNEL_SIZE,
  parameter logic [double_word_length-1:0] bias = BIAS,
  parameter bit saturate           = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [double_word_length*(image_size-kernel_size+1)
                *(image_size-kernel_size+1)-1:0] data_in,
  input  logic out_ready,
  output logic out_valid,
  output logic [double_word_length-1:0] data_out,
  output logic [OUT_IDX_W-1:0] out_index,
  output logic out_last,
  output logic busy,
  output logic drop_err
);

  localparam int output_size = image_size - kernel_size + 1;
  localparam int words       = output_size * output_size;
  localparam int buf_w       = double_word_length * words;

  localparam logic [OUT_IDX_W-1:0] LAST = OUT_IDX_W'(words - 1);

  state_t                        state;
  logic [buf_w-1:0]              buf_q;
  logic [double_word_length-1:0] word;
  logic [double_word_length-1:0] biased;
  logic                          hs;
  logic                          at_last;
  logic                          capture;

  assign hs      = out_valid && out_ready;
  assign at_last = out_index == LAST;
  assign capture = in_valid && (state == IDLE || (hs && at_last));

  // Map buffer needs no reset; it is only read while streaming
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q <= data_in;
    end
  end

  // Word select from registered buffer and registered index
  always_comb begin
    word = buf_q[int'(out_index)*double_word_length +: double_word_length];
  end

  bias_add_sat #(
    .width    (double_word_length),
    .bias     (bias),
    .saturate (saturate)
  ) u_bias (
    .a (word),
    .y (biased)
  );

  // Output bus is forced to zero whenever nothing is offered
  always_comb begin
    data_out = out_valid ? biased : '0;
  end

  // Stream FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      drop_err <= in_valid && state == STREAM && !(hs && at_last);
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= STREAM;
            out_index <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        STREAM: begin
          if (hs) begin
            if (!at_last) begin
              out_index <= out_index + 1'b1;
              out_last  <= (out_index + 1'b1) == LAST;
            end else if (in_valid) begin
              out_index <= '0;
              out_last  <= 1'b0;
            end else begin
              state     <= IDLE;
              out_index <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_serializer.sv
// Directed bench for conv_out_serializer: wrap and saturating
// instances share stimulus; expected words come from a small model.
module tb_conv_out_serializer;
  import conv_pkg::*;

  localparam int W = 16;
  localparam int N = 576;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W*N-1:0] data_in = '0;

  logic           v0, v1, l0, l1, b0, b1, d0, d1;
  logic [W-1:0]   q0, q1;
  logic [9:0]     i0, i1;

  int checks = 0;
  int failures = 0;

  conv_out_serializer #(.saturate(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .out_ready(out_ready), .out_valid(v0), .data_out(q0),
    .out_index(i0), .out_last(l0), .busy(b0), .drop_err(d0)
  );

  conv_out_serializer #(.saturate(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .out_ready(out_ready), .out_valid(v1), .data_out(q1),
    .out_index(i1), .out_last(l1), .busy(b1), .drop_err(d1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat(input int kind, input int w);
    logic [15:0] v;
    v = 16'(w);
    case (kind)
      1: v = 16'(w * 7);
      2: v = 16'(w + 1000);
      3: v = 16'(w + 5000);
      4: begin
        case (w)
          0: v = 16'h7FFA;
          1: v = 16'hFFF0;
          2: v = 16'h0000;
          3: v = 16'h8000;
          default: v = 16'(w);
        endcase
      end
      5: v = 16'(w) ^ 16'hA5A5;
      default: v = 16'(w);
    endcase
    return v;
  endfunction

  function automatic logic [15:0] expw(input int kind, input int w);
    return pat(kind, w) + 16'd14;
  endfunction

  task automatic load(input int kind);
    for (int w = 0; w < N; w++) data_in[W*w +: W] = pat(kind, w);
  endtask

  task automatic start(input int kind);
    load(kind);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    out_ready = 1'b1;
    cyc = 0;
    while (v0 && cyc < 700) begin
      step();
      cyc++;
    end
    chk("drain_valid", 32'(v0), 32'd0);
    chk("drain_busy", 32'(b0), 32'd0);
  endtask

  initial begin
    int exp_i;
    int cyc;

    // 1: reset and idle
    step();
    step();
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_data", 32'(q0), 32'd0);
    chk("rst_index", 32'(i0), 32'd0);
    chk("rst_last", 32'(l0), 32'd0);
    chk("rst_busy", 32'(b0), 32'd0);
    chk("rst_drop", 32'(d0), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("idle_valid", 32'(v0), 32'd0);
    end

    // 2: basic stream with out_ready high
    start(0);
    for (int w = 0; w < N; w++) begin
      chk("basic_valid", 32'(v0), 32'd1);
      chk("basic_index", 32'(i0), 32'(w));
      chk("basic_data", 32'(q0), 32'(16'(w + 14)));
      chk("basic_last", 32'(l0), 32'(w == N - 1));
      step();
    end
    chk("basic_end_valid", 32'(v0), 32'd0);
    chk("basic_end_busy", 32'(b0), 32'd0);

    // 3: pseudo-random backpressure
    start(1);
    exp_i = 0;
    cyc = 0;
    while (exp_i < N && cyc < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      chk("bp_valid", 32'(v0), 32'd1);
      chk("bp_index", 32'(i0), 32'(exp_i));
      chk("bp_data", 32'(q0), 32'(expw(1, exp_i)));
      chk("bp_last", 32'(l0), 32'(exp_i == N - 1));
      if (out_ready) exp_i++;
      step();
      cyc++;
    end
    chk("bp_budget", 32'(exp_i), 32'(N));
    chk("bp_end_valid", 32'(v0), 32'd0);

    // 4: overrun mid-stream, then back-to-back recapture
    out_ready = 1'b1;
    start(2);
    for (int k = 0; k < 100; k++) step();
    chk("ovr_index", 32'(i0), 32'd100);
    load(3);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ovr_drop", 32'(d0), 32'd1);
    chk("ovr_keep_idx", 32'(i0), 32'd101);
    chk("ovr_keep_data", 32'(q0), 32'(expw(2, 101)));
    step();
    chk("ovr_drop_once", 32'(d0), 32'd0);
    chk("ovr_keep_data2", 32'(q0), 32'(expw(2, 102)));
    for (int k = 102; k < N - 1; k++) step();
    chk("b2b_last", 32'(l0), 32'd1);
    chk("b2b_last_data", 32'(q0), 32'(expw(2, N - 1)));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("b2b_valid", 32'(v0), 32'd1);
    chk("b2b_index", 32'(i0), 32'd0);
    chk("b2b_data", 32'(q0), 32'(expw(3, 0)));
    chk("b2b_nodrop", 32'(d0), 32'd0);
    step();
    chk("b2b_data1", 32'(q0), 32'(expw(3, 1)));
    drain();

    // 5: arithmetic corners on wrap and saturating instances
    out_ready = 1'b0;
    start(4);
    step();
    chk("sat0_7ffa", 32'(q0), 32'h8008);
    chk("sat1_7ffa", 32'(q1), 32'h7FFF);
    out_ready = 1'b1;
    step();
    chk("sat0_fff0", 32'(q0), 32'hFFFE);
    chk("sat1_fff0", 32'(q1), 32'hFFFE);
    step();
    chk("sat0_zero", 32'(q0), 32'h000E);
    chk("sat1_zero", 32'(q1), 32'h000E);
    step();
    chk("sat0_8000", 32'(q0), 32'h800E);
    chk("sat1_8000", 32'(q1), 32'h800E);
    drain();

    // 6: asynchronous reset mid-stream, then restart
    start(5);
    for (int k = 0; k < 300; k++) step();
    chk("mid_index", 32'(i0), 32'd300);
    chk("mid_data", 32'(q0), 32'(expw(5, 300)));
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(v0), 32'd0);
    chk("arst_data", 32'(q0), 32'd0);
    chk("arst_index", 32'(i0), 32'd0);
    chk("arst_busy", 32'(b0), 32'd0);
    chk("arst_last", 32'(l0), 32'd0);
    chk("arst_valid1", 32'(v1), 32'd0);
    #1 rst = 1'b0;
    start(1);
    chk("rest_valid", 32'(v0), 32'd1);
    chk("rest_index", 32'(i0), 32'd0);
    chk("rest_data", 32'(q0), 32'(expw(1, 0)));
    step();
    chk("rest_data1", 32'(q0), 32'(expw(1, 1)));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
